// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : MIPS program counter with branch/jump resolution and one-slot
//            branch-delay handling; flags BLTZAL/BGEZAL and return to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        state,
    input  logic        N,
    input  logic        Z,
    input  logic [31:0] instruction_word,
    input  logic [31:0] read_data_0,
    output logic        B_link,
    output logic [31:0] addr,
    output logic        finish
);

    localparam logic [31:0] C_RESET_ADDR = 32'hBFC0_0000;

    localparam logic [5:0] C_OP_SPECIAL = 6'd0;
    localparam logic [5:0] C_OP_REGIMM  = 6'd1;
    localparam logic [5:0] C_OP_J       = 6'd2;
    localparam logic [5:0] C_OP_JAL     = 6'd3;
    localparam logic [5:0] C_OP_BEQ     = 6'd4;
    localparam logic [5:0] C_OP_BNE     = 6'd5;
    localparam logic [5:0] C_OP_BLEZ    = 6'd6;
    localparam logic [5:0] C_OP_BGTZ    = 6'd7;

    localparam logic [4:0] C_RT_BLTZ    = 5'd0;
    localparam logic [4:0] C_RT_BGEZ    = 5'd1;
    localparam logic [4:0] C_RT_BLTZAL  = 5'd16;
    localparam logic [4:0] C_RT_BGEZAL  = 5'd17;

    localparam logic [5:0] C_FN_JR      = 6'd8;
    localparam logic [5:0] C_FN_JALR    = 6'd9;

    logic [31:0] r_addr;
    logic        r_pending;
    logic [31:0] r_target;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [25:0] w_index;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_taken;
    logic        w_link_branch;
    logic [31:0] w_target;

    assign w_opcode = instruction_word[31:26];
    assign w_rt     = instruction_word[20:16];
    assign w_funct  = instruction_word[5:0];
    assign w_imm16  = instruction_word[15:0];
    assign w_index  = instruction_word[25:0];

    assign w_pc_plus4      = r_addr + 32'd4;
    assign w_branch_target = w_pc_plus4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_index, 2'b00};

    always_comb begin
        w_taken       = 1'b0;
        w_link_branch = 1'b0;
        w_target      = w_branch_target;
        case (w_opcode)
            C_OP_REGIMM: begin
                case (w_rt)
                    C_RT_BLTZ:   w_taken = N;
                    C_RT_BGEZ:   w_taken = ~N;
                    C_RT_BLTZAL: begin
                        w_taken       = N;
                        w_link_branch = 1'b1;
                    end
                    C_RT_BGEZAL: begin
                        w_taken       = ~N;
                        w_link_branch = 1'b1;
                    end
                    default:     w_taken = 1'b0;
                endcase
            end
            C_OP_BEQ:  w_taken = Z;
            C_OP_BNE:  w_taken = ~Z;
            C_OP_BLEZ: w_taken = N | Z;
            C_OP_BGTZ: w_taken = ~N & ~Z;
            C_OP_J, C_OP_JAL: begin
                w_taken  = 1'b1;
                w_target = w_jump_target;
            end
            C_OP_SPECIAL: begin
                if ((w_funct == C_FN_JR) || (w_funct == C_FN_JALR)) begin
                    w_taken  = 1'b1;
                    w_target = read_data_0;
                end
            end
            default: w_taken = 1'b0;
        endcase
    end

    // A control transfer seen while a target is pending sits in the delay
    // slot and is discarded; the earlier latched target takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= C_RESET_ADDR;
            r_pending <= 1'b0;
            r_target  <= 32'd0;
        end else if (state) begin
            if (r_pending) begin
                r_addr    <= r_target;
                r_pending <= 1'b0;
            end else if (w_taken) begin
                r_addr    <= w_pc_plus4;
                r_target  <= w_target;
                r_pending <= 1'b1;
            end else begin
                r_addr    <= w_pc_plus4;
            end
        end
    end

    assign addr   = r_addr;
    assign finish = (r_addr == 32'd0);
    assign B_link = state & w_link_branch;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit using an expected-address queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] C_NOP   = 32'h0000_0000;
    localparam logic [31:0] C_ADD   = 32'h0022_1820;
    localparam logic [31:0] C_RESET = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        state;
    logic        N;
    logic        Z;
    logic [31:0] instruction_word;
    logic [31:0] read_data_0;
    logic        B_link;
    logic [31:0] addr;
    logic        finish;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] r_cur_exp;

    pc_unit dut (
        .clk              (clk),
        .reset            (reset),
        .state            (state),
        .N                (N),
        .Z                (Z),
        .instruction_word (instruction_word),
        .read_data_0      (read_data_0),
        .B_link           (B_link),
        .addr             (addr),
        .finish           (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Fetch with junk on the execute-only inputs, then execute the instruction.
    task automatic run_instr(input string tag, input logic [31:0] instr, input logic n,
                             input logic z, input logic [31:0] rd0,
                             input logic [31:0] exp_addr, input logic exp_link);
        logic [31:0] popped;
        state            = 1'b0;
        instruction_word = 32'h0411_0002;
        N                = $urandom_range(0, 1) == 1;
        Z                = $urandom_range(0, 1) == 1;
        read_data_0      = $urandom;
        #1;
        check({tag, "_fetch_link"}, {31'd0, B_link}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_fetch_hold"}, addr, r_cur_exp);

        state            = 1'b1;
        instruction_word = instr;
        N                = n;
        Z                = z;
        read_data_0      = rd0;
        exp_q.push_back(exp_addr);
        #1;
        check({tag, "_link"}, {31'd0, B_link}, {31'd0, exp_link});
        @(posedge clk); #1;
        popped = exp_q.pop_front();
        check({tag, "_addr"}, addr, popped);
        check({tag, "_finish"}, {31'd0, finish}, {31'd0, (popped == 32'd0)});
        r_cur_exp = popped;
    endtask

    // Reset spans an execute cycle carrying a jump, which must not update addr.
    task automatic do_reset();
        reset            = 1'b1;
        state            = 1'b0;
        instruction_word = C_NOP;
        N                = 1'b0;
        Z                = 1'b0;
        read_data_0      = 32'd0;
        @(posedge clk); #1;
        state            = 1'b1;
        instruction_word = 32'h0800_0040;
        @(posedge clk); #1;
        reset = 1'b0;
        state = 1'b0;
        r_cur_exp = C_RESET;
        check("reset_addr", addr, C_RESET);
        check("reset_finish", {31'd0, finish}, 32'd0);
        check("reset_link", {31'd0, B_link}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        r_cur_exp = C_RESET;
        do_reset();

        run_instr("nop0",      C_NOP,        0, 0, 0, 32'hBFC0_0004, 0);
        run_instr("bltz_t",    32'h0400_0002, 1, 0, 0, 32'hBFC0_0008, 0);
        run_instr("bltz_ds",   C_ADD,        0, 0, 0, 32'hBFC0_0010, 0);
        run_instr("bltz_nt",   32'h0400_0002, 0, 0, 0, 32'hBFC0_0014, 0);
        run_instr("seq",       C_NOP,        0, 0, 0, 32'hBFC0_0018, 0);
        run_instr("bgezal_t",  32'h0411_0002, 0, 1, 0, 32'hBFC0_001C, 1);
        run_instr("bgezal_ds", C_NOP,        0, 0, 0, 32'hBFC0_0024, 0);
        run_instr("bgezal_nt", 32'h0411_0002, 1, 0, 0, 32'hBFC0_0028, 1);
        run_instr("seq2",      C_NOP,        0, 0, 0, 32'hBFC0_002C, 0);
        run_instr("bltzal_bk", 32'h0410_FFFE, 1, 0, 0, 32'hBFC0_0030, 1);
        run_instr("beq_in_ds", 32'h1000_0010, 0, 1, 0, 32'hBFC0_0028, 0);
        run_instr("beq_t",     32'h1000_0004, 0, 1, 0, 32'hBFC0_002C, 0);
        run_instr("beq_ds",    C_NOP,        0, 0, 0, 32'hBFC0_003C, 0);
        run_instr("bne_t",     32'h1400_0001, 0, 0, 0, 32'hBFC0_0040, 0);
        run_instr("bne_ds",    C_NOP,        0, 0, 0, 32'hBFC0_0044, 0);
        run_instr("blez_nt",   32'h1800_0001, 0, 0, 0, 32'hBFC0_0048, 0);
        run_instr("bgtz_t",    32'h1C00_0001, 0, 0, 0, 32'hBFC0_004C, 0);
        run_instr("bgtz_ds",   C_NOP,        0, 0, 0, 32'hBFC0_0050, 0);
        run_instr("jal",       32'h0C00_0001, 0, 0, 0, 32'hBFC0_0054, 0);
        run_instr("jal_ds",    C_NOP,        0, 0, 0, 32'hB000_0004, 0);
        run_instr("jalr",      32'h0000_0009, 0, 0, 32'h0000_0001, 32'hB000_0008, 0);
        run_instr("jalr_ds",   C_NOP,        0, 0, 0, 32'h0000_0001, 0);
        run_instr("jr",        32'h0000_0008, 0, 0, 32'h0000_0000, 32'h0000_0005, 0);
        run_instr("jr_ds",     C_NOP,        0, 0, 0, 32'h0000_0000, 0);

        do_reset();
        run_instr("nop1",      C_NOP,        0, 0, 0, 32'hBFC0_0004, 0);
        run_instr("j_pend",    32'h0800_0100, 0, 0, 0, 32'hBFC0_0008, 0);
        do_reset();
        run_instr("post_rst",  C_NOP,        0, 0, 0, 32'hBFC0_0004, 0);
        run_instr("post_rst2", C_NOP,        0, 0, 0, 32'hBFC0_0008, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
